// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared types and burst-sizing helpers for the write-DMA engine.
// Revision : 1.0  initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_CMD  = 2'd2,
        ST_DATA = 2'd3
    } dma_state_t;

    localparam int unsigned PAGE_BYTES = 4096;

    function automatic int unsigned bytes_per_beat(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Burst may not exceed the configured maximum, the words still to issue,
    // or the words left before the next 4 KB page boundary.
    function automatic logic [31:0] calc_beats(
        input logic [31:0] burst_len,
        input logic [31:0] words_left,
        input logic [31:0] page_off,
        input logic [31:0] bpb
    );
        logic [31:0] w_to_page;
        logic [31:0] w_beats;
        w_to_page = (PAGE_BYTES - page_off) / bpb;
        w_beats   = burst_len;
        if (words_left < w_beats) w_beats = words_left;
        if (w_to_page < w_beats)  w_beats = w_to_page;
        return w_beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_sync_fifo
// Purpose  : Single-clock staging FIFO with occupancy count and flush.
// Revision : 1.0  initial release
// ============================================================================
module dma_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_push = i_push & ~w_full;
    assign w_pop  = i_pop & (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule
`default_nettype wire

// File: rtl/dma_wr_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_wr_engine
// Purpose  : Write-DMA master: stages a word stream and writes it out as bursts.
// Revision : 1.0  initial release
// ============================================================================
module dma_wr_engine
    import dma_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 24,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              abort,
    output logic              busy,
    output logic              dma_done,
    output logic              aborted,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic [ADDR_W-1:0] m_cmd_addr,
    output logic [7:0]        m_cmd_len,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wlast
);

    localparam int unsigned BYTES_PER_BEAT = bytes_per_beat(DATA_W);
    localparam int          CNT_W          = $clog2(FIFO_DEPTH) + 1;

    dma_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_words_in;
    logic [LEN_W-1:0]  r_issued;
    logic [8:0]        r_beats;
    logic [8:0]        r_beat_cnt;
    logic              r_abort_pend;
    logic              r_busy;
    logic              r_dma_done;
    logic              r_aborted;
    logic              r_cmd_valid;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [7:0]        r_cmd_len;
    logic              r_wvalid;
    logic              r_wlast;

    logic              w_s_ready;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_fifo_flush;
    logic              w_fifo_full;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [DATA_W-1:0] w_fifo_head;
    logic [LEN_W-1:0]  w_words_left;
    logic [31:0]       w_beats32;
    logic              w_last_issue;
    logic [ADDR_W-1:0] w_burst_bytes;
    logic              w_cmd_abort;
    logic              w_burst_end;
    logic              w_data_abort;

    assign w_s_ready    = r_busy & ~w_fifo_full & (r_words_in < r_len);
    assign w_fifo_push  = s_valid & w_s_ready;
    assign w_fifo_pop   = r_wvalid & m_wready;

    assign w_words_left = r_len - r_issued;
    assign w_beats32    = calc_beats(32'(BURST_LEN), 32'(w_words_left),
                                     32'(r_addr[11:0]), 32'(BYTES_PER_BEAT));
    assign w_last_issue  = ((r_issued + LEN_W'(r_beats)) == r_len);
    assign w_burst_bytes = ADDR_W'(r_beats) * ADDR_W'(BYTES_PER_BEAT);

    // Abort before the command is accepted drops the job at once; after
    // acceptance the burst must run to m_wlast before the FIFO is flushed.
    assign w_cmd_abort  = abort & ((r_state == ST_FILL) |
                                   ((r_state == ST_CMD) & ~m_cmd_ready));
    assign w_burst_end  = (r_state == ST_DATA) & w_fifo_pop & r_wlast;
    assign w_data_abort = w_burst_end & ~w_last_issue & (r_abort_pend | abort);
    assign w_fifo_flush = w_cmd_abort | w_data_abort;

    dma_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_fifo_flush),
        .i_push  (w_fifo_push),
        .i_wdata (s_data),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_words_in   <= '0;
            r_issued     <= '0;
            r_beats      <= '0;
            r_beat_cnt   <= '0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_dma_done   <= 1'b0;
            r_aborted    <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
        end else begin
            r_dma_done <= 1'b0;
            r_aborted  <= 1'b0;
            if (w_fifo_push) r_words_in <= r_words_in + LEN_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr       <= cfg_base;
                        r_len        <= cfg_len;
                        r_words_in   <= '0;
                        r_issued     <= '0;
                        r_abort_pend <= 1'b0;
                        if (cfg_len == '0) begin
                            r_dma_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_cmd_abort) begin
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (32'(w_fifo_count) >= w_beats32) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_addr  <= r_addr;
                        r_cmd_len   <= 8'(w_beats32 - 32'd1);
                        r_beats     <= w_beats32[8:0];
                        r_state     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (m_cmd_ready) begin
                        r_cmd_valid  <= 1'b0;
                        r_wvalid     <= 1'b1;
                        r_wlast      <= (r_beats == 9'd1);
                        r_beat_cnt   <= '0;
                        r_abort_pend <= abort;
                        r_state      <= ST_DATA;
                    end else if (w_cmd_abort) begin
                        r_cmd_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_aborted   <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (abort) r_abort_pend <= 1'b1;
                    if (w_burst_end) begin
                        r_wvalid   <= 1'b0;
                        r_wlast    <= 1'b0;
                        r_beat_cnt <= '0;
                        r_addr     <= r_addr + w_burst_bytes;
                        r_issued   <= r_issued + LEN_W'(r_beats);
                        // Completion outranks a same-cycle abort.
                        if (w_last_issue) begin
                            r_busy     <= 1'b0;
                            r_dma_done <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else if (w_data_abort) begin
                            r_busy    <= 1'b0;
                            r_aborted <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end else if (w_fifo_pop) begin
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                        r_wlast    <= ((r_beat_cnt + 9'd2) == r_beats);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign dma_done    = r_dma_done;
    assign aborted     = r_aborted;
    assign s_ready     = w_s_ready;
    assign m_cmd_valid = r_cmd_valid;
    assign m_cmd_addr  = r_cmd_addr;
    assign m_cmd_len   = r_cmd_len;
    assign m_wvalid    = r_wvalid;
    assign m_wdata     = r_wvalid ? w_fifo_head : '0;
    assign m_wlast     = r_wlast;

endmodule
`default_nettype wire

// File: tb/tb_dma_wr_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_wr_engine
// Purpose  : Directed job table plus reset/abort sequences for dma_wr_engine.
// Revision : 1.0  initial release
// ============================================================================
module tb_dma_wr_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] cfg_base;
    logic [23:0] cfg_len;
    logic        abort;
    logic        busy;
    logic        dma_done;
    logic        aborted;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic [31:0] m_cmd_addr;
    logic [7:0]  m_cmd_len;
    logic        m_wvalid;
    logic        m_wready;
    logic [31:0] m_wdata;
    logic        m_wlast;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]       base;
        logic [23:0]       len;
        bit                stall;
        int                abort_burst;
        int                abort_beat;
        int                exp_ncmd;
        logic [7:0][31:0]  exp_addr;
        logic [7:0][7:0]   exp_lenm1;
        int                exp_beats;
        bit                exp_done;
        bit                exp_abort;
        int                exp_first;
    } vec_t;

    vec_t vecs[8];

    dma_wr_engine #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .LEN_W      (24),
        .BURST_LEN  (16),
        .FIFO_DEPTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_base    (cfg_base),
        .cfg_len     (cfg_len),
        .abort       (abort),
        .busy        (busy),
        .dma_done    (dma_done),
        .aborted     (aborted),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_ready (m_cmd_ready),
        .m_cmd_addr  (m_cmd_addr),
        .m_cmd_len   (m_cmd_len),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_wdata     (m_wdata),
        .m_wlast     (m_wlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] base, input logic [23:0] len,
                                 input bit stall, input int ab_burst, input int ab_beat,
                                 input int ncmd, input int beats, input bit done,
                                 input bit abrt, input int first);
        vec_t v;
        v.base        = base;
        v.len         = len;
        v.stall       = stall;
        v.abort_burst = ab_burst;
        v.abort_beat  = ab_beat;
        v.exp_ncmd    = ncmd;
        v.exp_addr    = '0;
        v.exp_lenm1   = '0;
        v.exp_beats   = beats;
        v.exp_done    = done;
        v.exp_abort   = abrt;
        v.exp_first   = first;
        return v;
    endfunction

    task automatic setc(input int vi, input int ci, input logic [31:0] a, input logic [7:0] l);
        vecs[vi].exp_addr[ci]  = a;
        vecs[vi].exp_lenm1[ci] = l;
    endtask

    // Runs one job; every cycle is handled at the falling edge.
    task automatic run_job(input int vi);
        vec_t        v;
        int          cyc, sidx, cmd_i, beat, total, cur_len;
        int          done_cnt, abort_cnt, done_cyc, abort_cyc, last_cyc, first_cyc, post;
        bit          in_burst, busy_seen, cmd_pend;
        logic [31:0] p_addr, dbase;
        logic [7:0]  p_len;
        v = vecs[vi];
        dbase = 32'hA000_0000 + (32'(vi) << 16);
        {sidx, cmd_i, beat, total, cur_len, done_cnt, abort_cnt} = '0;
        done_cyc = -1; abort_cyc = -1; last_cyc = -1; first_cyc = -1; post = -1;
        in_burst = 0; busy_seen = 0; cmd_pend = 0; p_addr = '0; p_len = '0;

        @(negedge clk);
        start = 1'b1; cfg_base = v.base; cfg_len = v.len; abort = 1'b0;
        s_valid = 1'b0; m_cmd_ready = 1'b0; m_wready = 1'b0;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) busy_seen = 1;
            if (dma_done) begin done_cnt++; done_cyc = cyc; end
            if (aborted) begin abort_cnt++; abort_cyc = cyc; end

            abort = in_burst && (cmd_i - 1 == v.abort_burst) && (beat == v.abort_beat);

            s_valid = (sidx < int'(v.len)) && (!v.stall || $urandom_range(0, 3) != 0);
            s_data  = dbase + 32'(sidx);
            if (s_valid && s_ready) sidx++;

            m_wready = !v.stall || $urandom_range(0, 3) != 0;
            if (!in_burst) chk("wvalid_idle", m_wvalid, 0);
            if (in_burst && beat > 0) chk("wvalid_gap", m_wvalid, 1);
            if (in_burst && m_wvalid && m_wready) begin
                chk("wdata", m_wdata, dbase + 32'(total));
                chk("wlast", m_wlast, beat == cur_len);
                beat++;
                total++;
                if (beat == cur_len + 1) begin in_burst = 0; last_cyc = cyc; end
            end

            m_cmd_ready = !v.stall || $urandom_range(0, 3) != 0;
            if (cmd_pend) begin
                chk("cmd_hold_valid", m_cmd_valid, 1);
                chk("cmd_hold_addr", m_cmd_addr, p_addr);
                chk("cmd_hold_len", m_cmd_len, p_len);
            end
            cmd_pend = 0;
            if (m_cmd_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("cmd_overlap", in_burst, 0);
                if (m_cmd_ready) begin
                    if (cmd_i < v.exp_ncmd) begin
                        chk("cmd_addr", m_cmd_addr, v.exp_addr[cmd_i]);
                        chk("cmd_len", m_cmd_len, v.exp_lenm1[cmd_i]);
                        cur_len = int'(v.exp_lenm1[cmd_i]);
                    end else begin
                        chk("cmd_extra", cmd_i + 1, v.exp_ncmd);
                        cur_len = int'(m_cmd_len);
                    end
                    cmd_i++;
                    in_burst = 1;
                    beat = 0;
                end else begin
                    cmd_pend = 1;
                    p_addr = m_cmd_addr;
                    p_len = m_cmd_len;
                end
            end

            if (post < 0 && (done_cnt + abort_cnt) > 0) post = cyc;
            if (post >= 0 && cyc >= post + 3) break;
            if (cyc > 3000) begin
                chk("job_timeout", 1, 0);
                break;
            end
        end
        s_valid = 1'b0; abort = 1'b0; m_cmd_ready = 1'b0; m_wready = 1'b0;

        chk("ncmd", cmd_i, v.exp_ncmd);
        chk("beats", total, v.exp_beats);
        chk("done_cnt", done_cnt, v.exp_done);
        chk("abort_cnt", abort_cnt, v.exp_abort);
        chk("busy_end", busy, 0);
        if (v.exp_done)  chk("done_lat", done_cyc, (v.len == 0) ? 1 : last_cyc + 1);
        if (v.exp_abort) chk("abort_lat", abort_cyc, last_cyc + 1);
        if (v.len == 0)  chk("busy_seen_len0", busy_seen, 0);
        if (v.exp_first > 0) chk("first_cmd_lat", first_cyc, v.exp_first);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_len = '0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; m_cmd_ready = 1'b0; m_wready = 1'b0;

        vecs[0] = mkv(32'h0000_1000, 24'd40, 0, -1, 0, 3, 40, 1, 0, 18);
        setc(0, 0, 32'h0000_1000, 8'd15); setc(0, 1, 32'h0000_1040, 8'd15);
        setc(0, 2, 32'h0000_1080, 8'd7);
        vecs[1] = mkv(32'h0000_0FF0, 24'd16, 0, -1, 0, 2, 16, 1, 0, 6);
        setc(1, 0, 32'h0000_0FF0, 8'd3); setc(1, 1, 32'h0000_1000, 8'd11);
        vecs[2] = mkv(32'h0000_3000, 24'd0, 0, -1, 0, 0, 0, 1, 0, 0);
        vecs[3] = mkv(32'h0000_1FFC, 24'd3, 0, -1, 0, 2, 3, 1, 0, 3);
        setc(3, 0, 32'h0000_1FFC, 8'd0); setc(3, 1, 32'h0000_2000, 8'd1);
        vecs[4] = mkv(32'hFFFF_FFF8, 24'd4, 0, -1, 0, 2, 4, 1, 0, 0);
        setc(4, 0, 32'hFFFF_FFF8, 8'd1); setc(4, 1, 32'h0000_0000, 8'd1);
        vecs[5] = mkv(32'h0000_0F00, 24'd100, 1, -1, 0, 7, 100, 1, 0, 0);
        setc(5, 0, 32'h0000_0F00, 8'd15); setc(5, 1, 32'h0000_0F40, 8'd15);
        setc(5, 2, 32'h0000_0F80, 8'd15); setc(5, 3, 32'h0000_0FC0, 8'd15);
        setc(5, 4, 32'h0000_1000, 8'd15); setc(5, 5, 32'h0000_1040, 8'd15);
        setc(5, 6, 32'h0000_1080, 8'd3);
        vecs[6] = mkv(32'h0000_1000, 24'd40, 0, 1, 4, 2, 32, 0, 1, 0);
        setc(6, 0, 32'h0000_1000, 8'd15); setc(6, 1, 32'h0000_1040, 8'd15);
        vecs[7] = mkv(32'h0000_2000, 24'd20, 0, -1, 0, 2, 20, 1, 0, 0);
        setc(7, 0, 32'h0000_2000, 8'd15); setc(7, 1, 32'h0000_2040, 8'd3);

        repeat (3) @(negedge clk);
        chk("rst_flags", {busy, dma_done, aborted, s_ready, m_cmd_valid, m_wvalid, m_wlast}, 0);
        chk("rst_bus", {m_cmd_addr, m_cmd_len, m_wdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ignored", {aborted, busy}, 0);

        for (int i = 0; i < 8; i++) run_job(i);

        // Reset in the middle of a burst, with a start pulse ignored while busy.
        @(negedge clk);
        start = 1'b1; cfg_base = 32'h0000_1000; cfg_len = 24'd40;
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clk);
            start = (i == 3); cfg_len = (i == 3) ? 24'd0 : 24'd40;
            chk("start_while_busy", dma_done, 0);
            s_valid = 1'b1; s_data = 32'h5555_0000 + 32'(i);
            m_cmd_ready = 1'b1; m_wready = 1'b1;
            if (m_wvalid) n++;
        end
        start = 1'b0;
        chk("pre_rst_beats", n, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {busy, dma_done, aborted, s_ready, m_cmd_valid, m_wvalid, m_wlast}, 0);
        chk("midrst_bus", {m_cmd_addr, m_cmd_len, m_wdata}, 0);
        s_valid = 1'b0; m_cmd_ready = 1'b0; m_wready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_job(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
